bn_sched: RTL and testbench
===========================

// Module: bn_sched
// PURPOSE
//  Sequencer for the batch-norm stage: drains the BN FIFO into the BN datapath and supplies the
//  matching per-channel mean/std/gamma/beta, one element per accepted read.
//  Holds a NUM_CH-entry parameter table written over a config port while idle.
//  Walks channel-major through NUM_CH x PIX_PER_CH elements per frame, then pulses done.
//  Its outputs feed the BN input pipeline register.
// PARAMETERS
//  DATA_WIDTH  16  width of each BN parameter and config data word (signed)
//  NUM_CH      8   channels per frame; parameter table depth (>=2)
//  PIX_PER_CH  64  elements per channel (>=2)
// PORTS
//  clk         in   1           clock, rising edge
//  rst         in   1           asynchronous active-low reset
//  cfg_we      in   1           parameter table write strobe
//  cfg_sel     in   2           0=mean 1=std 2=gamma 3=beta
//  cfg_ch      in   $clog2(NUM_CH)  channel index of write
//  cfg_data    in   DATA_WIDTH  signed write value
//  cfg_err     out  1           1-cycle pulse: cfg write rejected (busy or cfg_ch>=NUM_CH)
//  start       in   1           begin frame (sampled in IDLE only)
//  abort       in   1           synchronous cancel of current frame
//  busy        out  1           1 in RUN or DRAIN
//  done        out  1           1-cycle pulse after last element issued
//  fifo_empty  in   1           BN FIFO empty flag
//  fifo_rd_en  out  1           BN FIFO read strobe (comb); FIFO data valid next cycle
//  out_ready   in   1           downstream can take an element next cycle
//  bn_en       out  1           registered; element + params valid this cycle
//  bn_mean/bn_std/bn_gamma/bn_beta  out  DATA_WIDTH  registered params for current element
//  ch_idx      out  $clog2(NUM_CH)  registered channel of current element
//  last        out  1           registered; with bn_en on final element of frame
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE, counters 0, table 0; all outputs 0 (fifo_rd_en=0).
//  - FSM: IDLE -start-> RUN; RUN -read of final element-> DRAIN; DRAIN -1 cycle-> DONE;
//    DONE -1 cycle, done=1-> IDLE. abort in RUN/DRAIN/DONE -> IDLE next edge; no done pulse.
//  - fifo_rd_en = (state==RUN) && !fifo_empty && out_ready. Never asserted outside RUN.
//  - Read accepted when fifo_rd_en=1. Same edge: bn_en<=1; ch_idx<=ch_cnt; params<=table[ch_cnt];
//    last<=final element. Else bn_en<=0, last<=0, params/ch_idx hold.
//  - Latency: exactly 1 cycle read->bn_en, matching FIFO read latency.
//  - pix_cnt increments per read, wraps at PIX_PER_CH-1; wrap increments ch_cnt.
//    Read at (ch_cnt=NUM_CH-1, pix_cnt=PIX_PER_CH-1) is final: counters clear, go DRAIN.
//  - Stall: fifo_empty or !out_ready gaps are legal; counters, params and FSM hold.
//  - busy=1 in RUN and DRAIN only; start ignored while not IDLE.
//  - start with abort in same IDLE cycle: abort wins; stay IDLE.
//  - cfg write is accepted only in IDLE with cfg_ch<NUM_CH; it updates the table next edge.
//    Otherwise no table change and cfg_err=1 next cycle.
//  - cfg write with start in same IDLE cycle: write lands; frame uses new value.
//  - abort clears counters; table is kept. Next start begins at ch 0, pix 0.
//  - No arithmetic on parameters; values pass bit-exact (signed, DATA_WIDTH).
// TESTING
//  1 Reset mid-RUN (rst low at ch 3): all outputs 0 at once; table reads 0; FSM IDLE.
//  2 Program ch0 mean=16'sh0100 std=16'sh0200 gamma=-1 beta=5, ch1 distinct; FIFO never empty:
//    rd_en high 512 cycles; bn_en lags 1 cycle; params switch on 65th bn_en.
//    last on 512th bn_en; done 2 cycles after final read.
//  3 Random fifo_empty/out_ready gaps (NUM_CH=2, PIX_PER_CH=4): exactly 8 bn_en, ch_idx 0,0,0,0,1,1,1,1.
//    No read while empty or !out_ready.
//  4 cfg_we during RUN -> cfg_err pulse; table unchanged. cfg_ch=NUM_CH in IDLE -> cfg_err.
//  5 abort after 10 reads -> IDLE next edge, no done; restart -> ch_idx 0, full count.
//  6 start+abort same cycle -> stays IDLE; start while busy -> ignored, count unchanged.

Source files
------------

// File: rtl/bn_sched.sv
// bn_sched: walks the BN FIFO channel-major and issues each element with its channel's mean/std/gamma/beta.
// Read-to-bn_en latency is 1 cycle; fifo_empty or !out_ready stalls the walk in place.
module bn_sched #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_CH     = 8,
   parameter int PIX_PER_CH = 64
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cfg_we,
   input  logic [1:0]                   cfg_sel,
   input  logic [$clog2(NUM_CH)-1:0]    cfg_ch,
   input  logic signed [DATA_WIDTH-1:0] cfg_data,
   output logic                         cfg_err,
   input  logic                         start,
   input  logic                         abort,
   output logic                         busy,
   output logic                         done,
   input  logic                         fifo_empty,
   output logic                         fifo_rd_en,
   input  logic                         out_ready,
   output logic                         bn_en,
   output logic signed [DATA_WIDTH-1:0] bn_mean,
   output logic signed [DATA_WIDTH-1:0] bn_std,
   output logic signed [DATA_WIDTH-1:0] bn_gamma,
   output logic signed [DATA_WIDTH-1:0] bn_beta,
   output logic [$clog2(NUM_CH)-1:0]    ch_idx,
   output logic                         last
);
   localparam int CW = $clog2(NUM_CH);
   localparam int PW = $clog2(PIX_PER_CH);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   state_t state, state_nxt;

   logic [CW-1:0]         ch_cnt;
   logic [PW-1:0]         pix_cnt;
   logic [DATA_WIDTH-1:0] tbl [4][NUM_CH];   // [sel][channel]: mean, std, gamma, beta
   logic                  rd, final_rd, cfg_ok, pix_wrap;

   assign rd         = (state == RUN) && !fifo_empty && out_ready;
   assign fifo_rd_en = rd;
   assign pix_wrap   = (pix_cnt == PW'(PIX_PER_CH - 1));
   assign final_rd   = rd && pix_wrap && (ch_cnt == CW'(NUM_CH - 1));
   assign cfg_ok     = (state == IDLE) && (int'(cfg_ch) < NUM_CH);
   assign busy       = (state == RUN) || (state == DRAIN);
   assign done       = (state == DONE) && !abort;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start && !abort) state_nxt = RUN;
         RUN:     if (abort) state_nxt = IDLE;
                  else if (final_rd) state_nxt = DRAIN;
         DRAIN:   state_nxt = abort ? IDLE : DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < 4; s++)
            for (int c = 0; c < NUM_CH; c++)
               tbl[s][c] <= '0;
         cfg_err <= 1'b0;
      end else begin
         cfg_err <= cfg_we && !cfg_ok;
         if (cfg_we && cfg_ok) tbl[cfg_sel][cfg_ch] <= cfg_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ch_cnt  <= '0;
         pix_cnt <= '0;
      end else if (abort) begin
         ch_cnt  <= '0;
         pix_cnt <= '0;
      end else if (rd) begin
         if (pix_wrap) begin
            pix_cnt <= '0;
            ch_cnt  <= (ch_cnt == CW'(NUM_CH - 1)) ? '0 : ch_cnt + 1'b1;
         end else begin
            pix_cnt <= pix_cnt + 1'b1;
         end
      end
   end

   // Params and channel hold between reads so the datapath register sees stable values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bn_en    <= 1'b0;
         last     <= 1'b0;
         ch_idx   <= '0;
         bn_mean  <= '0;
         bn_std   <= '0;
         bn_gamma <= '0;
         bn_beta  <= '0;
      end else if (rd) begin
         bn_en    <= 1'b1;
         last     <= final_rd;
         ch_idx   <= ch_cnt;
         bn_mean  <= tbl[0][ch_cnt];
         bn_std   <= tbl[1][ch_cnt];
         bn_gamma <= tbl[2][ch_cnt];
         bn_beta  <= tbl[3][ch_cnt];
      end else begin
         bn_en <= 1'b0;
         last  <= 1'b0;
      end
   end
endmodule

// File: tb/tb_bn_sched.sv
// Randomized bench for bn_sched: frame-level model feeds a scoreboard that a negedge monitor drains.
module tb_bn_sched;
   localparam int DW    = 16;
   localparam int NCH   = 6;
   localparam int PIX   = 8;
   localparam int FRAME = NCH * PIX;
   localparam int CW    = $clog2(NCH);

   logic          clk, rst;
   logic          cfg_we, cfg_err, start, abort, busy, done;
   logic [1:0]    cfg_sel;
   logic [CW-1:0] cfg_ch, ch_idx;
   logic [DW-1:0] cfg_data, bn_mean, bn_std, bn_gamma, bn_beta;
   logic          fifo_empty, fifo_rd_en, out_ready, bn_en, last;

   bn_sched #(.DATA_WIDTH(DW), .NUM_CH(NCH), .PIX_PER_CH(PIX)) dut (
      .clk(clk), .rst(rst),
      .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_ch(cfg_ch), .cfg_data(cfg_data), .cfg_err(cfg_err),
      .start(start), .abort(abort), .busy(busy), .done(done),
      .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .out_ready(out_ready),
      .bn_en(bn_en), .bn_mean(bn_mean), .bn_std(bn_std), .bn_gamma(bn_gamma), .bn_beta(bn_beta),
      .ch_idx(ch_idx), .last(last)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic [CW-1:0] ch;
      logic [DW-1:0] mn, sd, gm, bt;
      logic          lst;
   } elem_t;

   int            checks = 0;
   int            errors = 0;
   elem_t         sbq[$];
   elem_t         me;
   logic [DW-1:0] mtbl [4][NCH];
   bit            m_run;
   int            k, tail;
   bit            exp_cfg_err;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < 4; s++)
         for (int c = 0; c < NCH; c++)
            mtbl[s][c] = '0;
      m_run = 0; k = 0; tail = 0; exp_cfg_err = 0;
      sbq.delete();
   endtask

   task automatic chk_zero();
      chk("rst_rd_en", fifo_rd_en, 0);
      chk("rst_bn_en", bn_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cfg_err", cfg_err, 0);
      chk("rst_last", last, 0);
      chk("rst_ch_idx", ch_idx, 0);
      chk("rst_params", {bn_mean, bn_std, bn_gamma, bn_beta}, 0);
   endtask

   // One clock cycle: entered and left at posedge+1. tail counts down the two post-frame cycles.
   task automatic cyc(input bit e, input bit r, input bit st, input bit ab);
      bit    exp_rd, idle, ok, run_n;
      int    tail_n, c;
      elem_t el;
      fifo_empty = e; out_ready = r; start = st; abort = ab;
      #1;
      exp_rd = m_run && !e && r;
      chk("fifo_rd_en", fifo_rd_en, exp_rd);
      chk("busy", busy, m_run || tail == 2);
      chk("done", done, tail == 1 && !ab);
      chk("cfg_err", cfg_err, exp_cfg_err);
      idle = !m_run && tail == 0;
      ok = idle && int'(cfg_ch) < NCH;
      exp_cfg_err = cfg_we && !ok;
      if (cfg_we && ok) mtbl[cfg_sel][cfg_ch] = cfg_data;
      run_n  = m_run;
      tail_n = (tail > 0) ? tail - 1 : 0;
      if (exp_rd) begin
         c      = k / PIX;
         el.ch  = CW'(c);
         el.mn  = mtbl[0][c];
         el.sd  = mtbl[1][c];
         el.gm  = mtbl[2][c];
         el.bt  = mtbl[3][c];
         el.lst = (k == FRAME - 1);
         sbq.push_back(el);
         k++;
         if (k == FRAME) begin k = 0; run_n = 0; tail_n = 2; end
      end
      if (st && !ab && idle) run_n = 1;
      if (ab) begin run_n = 0; tail_n = 0; k = 0; end
      @(posedge clk); #1;
      m_run = run_n;
      tail  = tail_n;
   endtask

   task automatic cfg_wr(input logic [1:0] s, input logic [CW-1:0] c, input logic [DW-1:0] d, input bit st);
      cfg_we = 1; cfg_sel = s; cfg_ch = c; cfg_data = d;
      cyc(1, 0, st, 0);
      cfg_we = 0;
   endtask

   task automatic run_frame(input int p_gap, input bit poke_start);
      int n = 0;
      while ((m_run || tail != 0) && n < 4000) begin
         cyc($urandom_range(99) < p_gap, !($urandom_range(99) < p_gap),
             poke_start && ($urandom_range(7) == 0), 0);
         n++;
      end
      chk("frame_timeout", n < 4000, 1);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (bn_en) begin
            if (sbq.size() == 0) chk("bn_en_unexpected", 1, 0);
            else begin
               me = sbq.pop_front();
               chk("ch_idx", ch_idx, me.ch);
               chk("bn_mean", bn_mean, me.mn);
               chk("bn_std", bn_std, me.sd);
               chk("bn_gamma", bn_gamma, me.gm);
               chk("bn_beta", bn_beta, me.bt);
               chk("last", last, me.lst);
            end
         end else begin
            chk("last_without_bn_en", last, 0);
         end
      end
   end

   initial begin
      rst = 0; cfg_we = 0; cfg_sel = 0; cfg_ch = 0; cfg_data = 0;
      start = 0; abort = 0; fifo_empty = 1; out_ready = 0;
      model_reset();
      #2;
      chk_zero();
      @(posedge clk); #1;
      rst = 1;

      // program table; channel 0 gets fixed values including a negative gamma
      cfg_wr(0, 0, 16'h0100, 0);
      cfg_wr(1, 0, 16'h0200, 0);
      cfg_wr(2, 0, 16'hFFFF, 0);
      cfg_wr(3, 0, 16'h0005, 0);
      for (int c = 1; c < NCH; c++)
         for (int s = 0; s < 4; s++)
            cfg_wr(2'(s), CW'(c), DW'($urandom), 0);

      // full-rate frame, then a gappy frame with stray start pulses while busy
      cyc(1, 0, 1, 0); run_frame(0, 0);
      cyc(1, 0, 1, 0); run_frame(40, 1);

      // config writes while running are rejected
      cyc(1, 0, 1, 0);
      for (int i = 0; i < 6; i++) begin
         cfg_we = 1; cfg_sel = 2'($urandom); cfg_ch = CW'($urandom_range(NCH - 1)); cfg_data = DW'($urandom);
         cyc(0, 1, 0, 0);
      end
      cfg_we = 0;
      run_frame(30, 0);

      // out-of-range channel in idle
      cfg_wr(1, CW'(NCH), 16'h1234, 0);
      cfg_wr(2, CW'(NCH + 1), 16'h4321, 0);
      cyc(1, 0, 0, 0);

      // abort after 10 reads, then a full restart
      cyc(1, 0, 1, 0);
      while (k < 10) cyc(0, 1, 0, 0);
      cyc(1, 0, 0, 1);
      repeat (4) cyc(1, 0, 0, 0);
      cyc(1, 0, 1, 0); run_frame(20, 0);

      // start and abort together stay idle
      cyc(1, 0, 1, 1);
      repeat (3) cyc(0, 1, 0, 0);

      // write landing in the same cycle as start is used by that frame
      cfg_wr(0, 0, 16'h8001, 1);
      run_frame(0, 0);

      // reset in the middle of channel 3
      cyc(1, 0, 1, 0);
      while (k < 3 * PIX + 2) cyc(0, 1, 0, 0);
      rst = 0;
      #1;
      chk_zero();
      model_reset();
      rst = 1;
      @(posedge clk); #1;
      cyc(1, 0, 1, 0); run_frame(20, 0);

      repeat (3) cyc(1, 0, 0, 0);
      chk("scoreboard_drained", sbq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
